rtc_timer_array: RTL and testbench
==================================

Name: rtc_timer_array

Overview:
- Parametrised successor to the single-channel RTC timer.
- A calibrated prescaler turns the core clock into a periodic tick.
- N_TIMERS independent timers count that tick, each in one-shot or periodic mode, with per-channel sticky event flags, masks and an aggregated event output.
- Sits beside rtc_clock/rtc_date under the RTC top and is driven by the same register-interface strobes.

Parameters:
N_TIMERS, 4, number of timer channels (1..16)
TIMER_W, 17, timer target/value width in bits
CAL_W, 16, prescaler calibration width in bits

Ports:
clk_i  in  1  RTC clock
rstn_i  in  1  asynchronous active-low reset
calibre_update_i  in  1  load prescaler calibration
calibre_sec_cnt_i  in  CAL_W  clk cycles per tick minus 1
calibre_sec_cnt_o  out  CAL_W  current calibration value
timer_update_i  in  N_TIMERS  per-channel load strobe
timer_enable_i  in  N_TIMERS  per-channel enable (level)
timer_mode_i  in  N_TIMERS  0 = one-shot, 1 = periodic (sampled on update)
timer_target_i  in  N_TIMERS*TIMER_W  per-channel target; channel k at bits [k*TIMER_W +: TIMER_W]
timer_value_o  out  N_TIMERS*TIMER_W  per-channel current count, same packing
event_mask_i  in  N_TIMERS  1 = flag contributes to event_o
event_flag_clr_i  in  N_TIMERS  write-1-to-clear flag strobe
event_flag_o  out  N_TIMERS  sticky per-channel event flags
tick_o  out  1  one-cycle tick pulse
event_o  out  1  OR of masked flags

Behaviour:
- Reset (async, rstn_i low):
  - prescaler counter = 0, calibration = 0x7FFF, tick_o = 0
  - all timer values, targets and mode bits = 0; all states IDLE
  - event_flag_o = 0, event_o = 0
- Prescaler:
  - Counter increments every cycle.
  - When counter == calibration: counter -> 0 and tick_o is registered high for exactly the next cycle.
  - Period = calibration + 1 cycles. Calibration 0 gives tick_o high every cycle.
  - calibre_update_i: calibration <= calibre_sec_cnt_i and counter <= 0; no tick is generated from that cycle's compare.
- Timer state machine, per channel k, states IDLE / RUN / DONE:
  - timer_update_i[k]: target <= slice, mode <= timer_mode_i[k], value <= 0. Next state is RUN if timer_enable_i[k], else IDLE. Update has priority over tick and enable in the same cycle.
  - IDLE: value held. Goes to RUN when timer_enable_i[k] = 1 and the current value < target; otherwise (value >= target) it stays IDLE and no flag is set.
  - RUN, timer_enable_i[k] = 0: go to IDLE, value held (pause).
  - RUN, tick_o = 1, value + 1 == target:
    - event_flag[k] <= 1
    - periodic: value <= 0, stay RUN
    - one-shot: value <= target, go to DONE
  - RUN, tick_o = 1, otherwise: value <= value + 1, modulo 2^TIMER_W.
  - Target 0: never matches; value wraps freely and no flag is ever set.
  - DONE: value frozen at target. Leaves only via update, or via timer_enable_i[k] = 0, which goes to IDLE with value <= 0.
  - Enable = 1 in DONE or IDLE does not retrigger; reloading requires timer_update_i[k].
- Flags:
  - Set by an expiry; cleared by event_flag_clr_i[k].
  - Set and clear in the same cycle: set wins.
  - Flags are independent of the mask; the mask gates only event_o.
- event_o = |(event_flag_o & event_mask_i), combinational from registered flags. Latency from the expiring tick cycle to event_o = 1 cycle.
- Channels are fully independent; any number may expire on the same tick.
- Reset mid-count returns everything to reset values immediately; no tick or flag is produced on reset release.

Test Plan:
- Prescaler: calibration 3 -> tick_o pulses every 4 cycles; calibre_sec_cnt_o = 3. Mid-period update to 1 -> counter restarts, then a tick every 2 cycles.
- One-shot: calibration 0, ch0 update target 5, mode 0, enable 1 -> flag[0] rises after the 5th tick; value_o ch0 holds 5; state DONE with no further flags; clear flag -> stays 0.
- Periodic: ch1 target 3, mode 1 -> flag set after ticks 3, 6, 9. Clear asserted on the same cycle as the 6th-tick expiry -> flag stays 1.
- Pause/resume: ch2 target 10, disable at value 4 for 20 ticks -> value stays 4; re-enable -> flag after 6 more ticks.
- Mask/aggregation: flags {1,0,1,0}, mask 0b0100 -> event_o = 1; mask 0b0010 -> event_o = 0. Simultaneous expiry on ch0 and ch3 sets both flags on the same cycle.
- Corners: target 0 -> value wraps 0x1FFFF -> 0 with no flag. Update and tick in the same cycle -> value 0. Reset asserted mid-count -> all outputs 0, calibration 0x7FFF.

Source files
------------

// File: rtl/rtc_timer_array.sv
// rtc_timer_array: calibrated tick prescaler feeding N one-shot/periodic timers with sticky, maskable event flags
//   clk_i / rstn_i          : RTC clock, asynchronous active-low reset
//   calibre_*               : prescaler calibration load, value in (cycles per tick - 1) and readback
//   timer_update/enable/mode: per-channel load strobe, run level, mode (0 one-shot, 1 periodic)
//   timer_target_i/value_o  : per-channel target in / count out, channel k at [k*TIMER_W +: TIMER_W]
//   event_mask/flag_clr/flag: per-channel event mask, write-1-to-clear strobe, sticky flags
//   tick_o / event_o        : one-cycle tick pulse, OR of masked flags
module rtc_timer_array #(
    parameter int N_TIMERS = 4,
    parameter int TIMER_W  = 17,
    parameter int CAL_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         calibre_update_i,
    input  logic [CAL_W-1:0]             calibre_sec_cnt_i,
    output logic [CAL_W-1:0]             calibre_sec_cnt_o,
    input  logic [N_TIMERS-1:0]          timer_update_i,
    input  logic [N_TIMERS-1:0]          timer_enable_i,
    input  logic [N_TIMERS-1:0]          timer_mode_i,
    input  logic [N_TIMERS*TIMER_W-1:0]  timer_target_i,
    output logic [N_TIMERS*TIMER_W-1:0]  timer_value_o,
    input  logic [N_TIMERS-1:0]          event_mask_i,
    input  logic [N_TIMERS-1:0]          event_flag_clr_i,
    output logic [N_TIMERS-1:0]          event_flag_o,
    output logic                         tick_o,
    output logic                         event_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [CAL_W-1:0]   cnt_q, cnt_d, cal_q, cal_d;
    logic               tick_q, tick_d;
    state_t             state_q [N_TIMERS];
    state_t             state_d [N_TIMERS];
    logic [TIMER_W-1:0] val_q [N_TIMERS];
    logic [TIMER_W-1:0] val_d [N_TIMERS];
    logic [TIMER_W-1:0] tgt_q [N_TIMERS];
    logic [TIMER_W-1:0] tgt_d [N_TIMERS];
    logic [N_TIMERS-1:0] mode_q, mode_d, flag_q, flag_d;

    // A calibration load restarts the period and swallows that cycle's compare
    always_comb begin
        cal_d  = calibre_update_i ? calibre_sec_cnt_i : cal_q;
        tick_d = !calibre_update_i && (cnt_q == cal_q);
        cnt_d  = (calibre_update_i || cnt_q == cal_q) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        for (int k = 0; k < N_TIMERS; k++) begin
            state_d[k] = state_q[k];
            val_d[k]   = val_q[k];
            tgt_d[k]   = tgt_q[k];
            mode_d[k]  = mode_q[k];
            flag_d[k]  = flag_q[k] & ~event_flag_clr_i[k];
            if (timer_update_i[k]) begin
                tgt_d[k]   = timer_target_i[k*TIMER_W +: TIMER_W];
                mode_d[k]  = timer_mode_i[k];
                val_d[k]   = '0;
                state_d[k] = timer_enable_i[k] ? RUN : IDLE;
            end else begin
                case (state_q[k])
                    IDLE: if (timer_enable_i[k] && val_q[k] < tgt_q[k]) state_d[k] = RUN;
                    RUN: begin
                        if (!timer_enable_i[k]) begin
                            state_d[k] = IDLE;
                        end else if (tick_q) begin
                            // Target 0 is excluded so the free-running wrap to 0 never counts as expiry
                            if (tgt_q[k] != '0 && val_q[k] + 1'b1 == tgt_q[k]) begin
                                flag_d[k]  = 1'b1;
                                val_d[k]   = mode_q[k] ? '0 : tgt_q[k];
                                state_d[k] = mode_q[k] ? RUN : DONE;
                            end else begin
                                val_d[k] = val_q[k] + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (!timer_enable_i[k]) begin
                            state_d[k] = IDLE;
                            val_d[k]   = '0;
                        end
                    end
                    default: state_d[k] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            cal_q  <= CAL_W'(15'h7FFF);
            tick_q <= 1'b0;
            mode_q <= '0;
            flag_q <= '0;
            for (int k = 0; k < N_TIMERS; k++) begin
                state_q[k] <= IDLE;
                val_q[k]   <= '0;
                tgt_q[k]   <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            cal_q  <= cal_d;
            tick_q <= tick_d;
            mode_q <= mode_d;
            flag_q <= flag_d;
            for (int k = 0; k < N_TIMERS; k++) begin
                state_q[k] <= state_d[k];
                val_q[k]   <= val_d[k];
                tgt_q[k]   <= tgt_d[k];
            end
        end
    end

    for (genvar g = 0; g < N_TIMERS; g++) begin : g_val
        assign timer_value_o[g*TIMER_W +: TIMER_W] = val_q[g];
    end

    assign calibre_sec_cnt_o = cal_q;
    assign tick_o            = tick_q;
    assign event_flag_o      = flag_q;
    assign event_o           = |(flag_q & event_mask_i);
endmodule

// File: tb/tb_rtc_timer_array.sv
// tb_rtc_timer_array: directed, table-driven check of prescaler, timer modes, flags and event aggregation
module tb_rtc_timer_array;
    localparam int N = 4;
    localparam int W = 17;
    localparam int C = 16;

    typedef struct {
        logic        upd;
        logic        en;
        logic        mode;
        logic [W-1:0] tgt;
        logic [N-1:0] clr;
        int          ch;
        logic [W-1:0] exp_val;
        logic [N-1:0] exp_flag;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic cal_upd;
    logic [C-1:0] cal_in, cal_o;
    logic [N-1:0] upd, en, mode, mask, clr, flag;
    logic [N*W-1:0] tgt, val;
    logic tick, ev;
    logic s_upd, s_en, s_mode, s_mask, s_clr, s_flag, s_tick, s_ev;
    logic [3:0] s_tgt, s_val, s_cal_o;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    rtc_timer_array dut (
        .clk_i(clk), .rstn_i(rstn),
        .calibre_update_i(cal_upd), .calibre_sec_cnt_i(cal_in), .calibre_sec_cnt_o(cal_o),
        .timer_update_i(upd), .timer_enable_i(en), .timer_mode_i(mode),
        .timer_target_i(tgt), .timer_value_o(val),
        .event_mask_i(mask), .event_flag_clr_i(clr), .event_flag_o(flag),
        .tick_o(tick), .event_o(ev)
    );

    // Narrow instance so the full-range wrap of a target-0 timer fits in a short run
    rtc_timer_array #(.N_TIMERS(1), .TIMER_W(4), .CAL_W(4)) u_small (
        .clk_i(clk), .rstn_i(rstn),
        .calibre_update_i(cal_upd), .calibre_sec_cnt_i(cal_in[3:0]), .calibre_sec_cnt_o(s_cal_o),
        .timer_update_i(s_upd), .timer_enable_i(s_en), .timer_mode_i(s_mode),
        .timer_target_i(s_tgt), .timer_value_o(s_val),
        .event_mask_i(s_mask), .event_flag_clr_i(s_clr), .event_flag_o(s_flag),
        .tick_o(s_tick), .event_o(s_ev)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic u, input logic e, input logic m, input logic [W-1:0] t,
                                input logic [N-1:0] c, input int ch, input logic [W-1:0] ev_,
                                input logic [N-1:0] ef);
        vec_t v;
        v.upd = u; v.en = e; v.mode = m; v.tgt = t; v.clr = c; v.ch = ch;
        v.exp_val = ev_; v.exp_flag = ef;
        return v;
    endfunction

    function automatic logic [W-1:0] chval(input int ch);
        return val[ch*W +: W];
    endfunction

    task automatic run_tab(input string tag);
        for (int i = 0; i < tab.size(); i++) begin
            upd[tab[i].ch]          = tab[i].upd;
            en[tab[i].ch]           = tab[i].en;
            mode[tab[i].ch]         = tab[i].mode;
            tgt[tab[i].ch*W +: W]   = tab[i].tgt;
            clr                     = tab[i].clr;
            step();
            upd = '0;
            clr = '0;
            chk($sformatf("%s[%0d] value", tag, i), chval(tab[i].ch), tab[i].exp_val);
            chk($sformatf("%s[%0d] flags", tag, i), flag, tab[i].exp_flag);
        end
        tab.delete();
    endtask

    initial begin
        rstn = 1'b0; cal_upd = 1'b0; cal_in = '0;
        upd = '0; en = '0; mode = '0; mask = '0; clr = '0; tgt = '0;
        s_upd = 1'b0; s_en = 1'b0; s_mode = 1'b0; s_mask = 1'b1; s_clr = 1'b0; s_tgt = '0;
        repeat (3) step();
        chk("reset cal", cal_o, 16'h7FFF);
        chk("reset tick", tick, 0);
        chk("reset values", val, 0);
        chk("reset flags", flag, 0);
        chk("reset event", ev, 0);
        rstn = 1'b1;
        step();

        // prescaler: calibration 3, then an update on the compare cycle, then calibration 1
        cal_upd = 1'b1; cal_in = 16'd3;
        step();
        cal_upd = 1'b0;
        chk("cal readback", cal_o, 3);
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("tick cal3 %0d", i), tick, (i % 4 == 3));
        end
        cal_upd = 1'b1; cal_in = 16'd1;
        step();
        cal_upd = 1'b0;
        chk("tick suppressed on update", tick, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("tick cal1 %0d", i), tick, (i % 2 == 1));
        end
        cal_upd = 1'b1; cal_in = 16'd0;
        step();
        cal_upd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tick cal0 %0d", i), tick, 1);
        end

        // one-shot ch0 target 5, tick every cycle from here on
        tab.push_back(mk(1, 1, 0, 5, 4'b0000, 0, 0, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 1, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 2, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 3, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 4, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 5, 4'b0001));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 5, 4'b0001));
        tab.push_back(mk(0, 1, 0, 5, 4'b0001, 0, 5, 4'b0000));
        tab.push_back(mk(0, 1, 0, 5, 4'b0000, 0, 5, 4'b0000));
        tab.push_back(mk(0, 0, 0, 5, 4'b0000, 0, 0, 4'b0000));
        run_tab("oneshot");

        // periodic ch1 target 3, clears including one on the expiry cycle
        tab.push_back(mk(1, 1, 1, 3, 4'b0000, 1, 0, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 1, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 2, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 0, 4'b0010));
        tab.push_back(mk(0, 1, 1, 3, 4'b0010, 1, 1, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 2, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0010, 1, 0, 4'b0010));
        tab.push_back(mk(0, 1, 1, 3, 4'b0010, 1, 1, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 2, 4'b0000));
        tab.push_back(mk(0, 1, 1, 3, 4'b0000, 1, 0, 4'b0010));
        tab.push_back(mk(0, 0, 1, 3, 4'b0000, 1, 0, 4'b0010));
        tab.push_back(mk(0, 0, 1, 3, 4'b0010, 1, 0, 4'b0000));
        run_tab("periodic");

        // pause/resume ch2 target 10
        upd[2] = 1'b1; en[2] = 1'b1; mode[2] = 1'b0; tgt[2*W +: W] = 17'd10;
        step();
        upd = '0;
        chk("pause load", chval(2), 0);
        repeat (4) step();
        chk("pause before", chval(2), 4);
        en[2] = 1'b0;
        step();
        chk("pause enter", chval(2), 4);
        repeat (20) step();
        chk("pause held", chval(2), 4);
        chk("pause no flag", flag, 0);
        en[2] = 1'b1;
        step();
        chk("resume edge", chval(2), 4);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("resume value %0d", i), chval(2), 4 + i);
            chk($sformatf("resume flag %0d", i), flag, 0);
        end
        step();
        chk("resume expire value", chval(2), 10);
        chk("resume expire flag", flag, 4'b0100);
        step();
        chk("done frozen", chval(2), 10);

        // simultaneous expiry on ch0 and ch3, event_o through mask bit 3
        mask = 4'b1000;
        upd = 4'b1001; en[0] = 1'b1; en[3] = 1'b1; mode[0] = 1'b0; mode[3] = 1'b0;
        tgt[0 +: W] = 17'd2; tgt[3*W +: W] = 17'd2;
        step();
        upd = '0;
        step();
        chk("simul pre flags", flag, 4'b0100);
        chk("simul pre event", ev, 0);
        step();
        chk("simul flags", flag, 4'b1101);
        chk("simul event", ev, 1);
        chk("simul ch0", chval(0), 2);
        chk("simul ch3", chval(3), 2);
        clr = 4'b1000;
        step();
        clr = '0;
        chk("clear ch3", flag, 4'b0101);

        // mask table against flags {ch0, ch2}
        begin
            logic [N-1:0] m_tab [7];
            logic         e_tab [7];
            m_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b1111};
            e_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 7; i++) begin
                mask = m_tab[i];
                #1;
                chk($sformatf("mask %b", m_tab[i]), ev, e_tab[i]);
            end
        end

        // update in the same cycle as a tick restarts at 0
        upd[1] = 1'b1; en[1] = 1'b1; mode[1] = 1'b0; tgt[W +: W] = 17'd100;
        step();
        upd = '0;
        repeat (3) step();
        chk("upd+tick pre", chval(1), 3);
        chk("upd+tick tick", tick, 1);
        upd[1] = 1'b1;
        step();
        upd = '0;
        chk("upd+tick value", chval(1), 0);
        step();
        chk("upd+tick next", chval(1), 1);

        // target 0 wraps freely without a flag (narrow instance)
        s_upd = 1'b1; s_en = 1'b1; s_tgt = 4'd0;
        step();
        s_upd = 1'b0;
        chk("wrap load", s_val, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("wrap value %0d", i), s_val, i % 16);
            chk($sformatf("wrap flag %0d", i), s_flag, 0);
        end

        // asynchronous reset mid-count
        #2;
        rstn = 1'b0;
        #1;
        chk("async rst cal", cal_o, 16'h7FFF);
        chk("async rst tick", tick, 0);
        chk("async rst values", val, 0);
        chk("async rst flags", flag, 0);
        chk("async rst event", ev, 0);
        chk("async rst small value", s_val, 0);
        chk("async rst small cal", s_cal_o, 4'hF);
        step();
        step();
        #2;
        rstn = 1'b1;
        repeat (3) step();
        chk("post rst tick", tick, 0);
        chk("post rst flags", flag, 0);
        chk("post rst values", val, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
